// File: rtl/bcd_count_ctrl_pkg.sv
// Shared definitions for the BCD run-control sequencer.
//   BCD_W   : bits per decade
//   BCD_MAX : largest legal decade value
//   state_e : sequencer states
package bcd_ctrl_pkg;

  localparam int               BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/bcd_decade.sv
// One synchronous BCD decade of the cascaded counter.
//   clk, reset : clock, async active-high reset
//   i_zero     : synchronous clear (wins over i_inc)
//   i_inc      : carry-in enable, advance by one this cycle
//   o_digit    : current decade value 0..9
//   o_is9      : decade sits at 9 (feeds the carry chain)
module bcd_decade
  import bcd_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_zero,
  input  logic             i_inc,
  output logic [BCD_W-1:0] o_digit,
  output logic             o_is9
);

  logic [BCD_W-1:0] r_digit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_digit <= '0;
    else if (i_zero) r_digit <= '0;
    else if (i_inc)  r_digit <= (r_digit == BCD_MAX) ? '0 : r_digit + 4'd1;
  end

  assign o_digit = r_digit;
  assign o_is9   = (r_digit == BCD_MAX);

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run-control sequencer for a DIGITS-decade BCD counter.
// Accepts start/stop/clear, divides clk by PRESCALE into a count tick,
// advances the decade chain and handles the terminal (limit) match.
//   clk, reset : clock, async active-high reset
//   start/stop/clear : one-cycle commands (clear > stop > start > tick)
//   wrap_en    : at terminal value, 1 = wrap to 0, 0 = halt in DONE
//   limit      : BCD terminal value, latched when start is accepted
//   count      : current BCD value, digit 0 in [3:0]
//   running    : state is RUN
//   done       : one-cycle pulse per terminal event
//   overflow   : sticky, all-9s rolled to 0 without a limit match
//   limit_err  : sticky, start rejected for a non-BCD limit digit
module bcd_count_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    wrap_en,
  input  logic [BCD_W*DIGITS-1:0] limit,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    running,
  output logic                    done,
  output logic                    overflow,
  output logic                    limit_err
);

  localparam int            CW       = BCD_W * DIGITS;
  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  state_e        r_state, w_state_nxt;
  logic [PW-1:0] r_pre, w_pre_nxt;
  logic [CW-1:0] r_limit;
  logic          r_running, r_done, r_overflow, r_limit_err;

  logic [DIGITS-1:0] w_is9, w_carry, w_lim_ok;
  logic [CW-1:0]     w_count;

  logic w_idle_done, w_stop_act, w_start_new, w_start_bad, w_resume;
  logic w_tick, w_term, w_inc, w_zero, w_all9_roll;

  // ---- decade chain --------------------------------------------------------
  // Digit k advances when the tick increments and every lower digit is 9.
  assign w_carry[0] = 1'b1;
  for (genvar k = 1; k < DIGITS; k++) begin : g_carry
    assign w_carry[k] = w_carry[k-1] & w_is9[k-1];
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_dec
    bcd_decade u_dec (
      .clk     (clk),
      .reset   (reset),
      .i_zero  (w_zero),
      .i_inc   (w_inc & w_carry[k]),
      .o_digit (w_count[BCD_W*k +: BCD_W]),
      .o_is9   (w_is9[k])
    );
    assign w_lim_ok[k] = (limit[BCD_W*k +: BCD_W] <= BCD_MAX);
  end

  // ---- command decode (priority clear > stop > start > tick) ---------------
  assign w_idle_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_stop_act  = !clear && stop && (r_state == ST_RUN);
  assign w_start_new = !clear && !w_stop_act && start && w_idle_done &&  (&w_lim_ok);
  assign w_start_bad = !clear && !w_stop_act && start && w_idle_done && !(&w_lim_ok);
  assign w_resume    = !clear && !w_stop_act && start && (r_state == ST_PAUSED);

  // A start in RUN is ignored, so it does not suppress the tick.
  assign w_tick      = !clear && !w_stop_act && (r_state == ST_RUN) && (r_pre == PRE_LAST);
  assign w_term      = w_tick && (w_count == r_limit);
  assign w_inc       = w_tick && !w_term;
  assign w_all9_roll = w_inc && (&w_is9);
  assign w_zero      = clear || w_start_new || (w_term && wrap_en);

  // ---- next state / prescaler ----------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    if (clear) begin
      w_state_nxt = ST_IDLE;
      w_pre_nxt   = '0;
    end else if (w_stop_act) begin
      w_state_nxt = ST_PAUSED;          // prescaler holds
    end else if (w_start_new) begin
      w_state_nxt = ST_RUN;
      w_pre_nxt   = '0;
    end else if (w_resume) begin
      w_state_nxt = ST_RUN;             // resumes from the held prescaler value
    end else if (r_state == ST_RUN) begin
      w_pre_nxt = (r_pre == PRE_LAST) ? '0 : r_pre + PW'(1);
      if (w_term && !wrap_en) w_state_nxt = ST_DONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pre       <= '0;
      r_limit     <= '0;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_limit_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pre     <= w_pre_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_done    <= w_term;
      if (w_start_new) r_limit <= limit;

      if (clear)            r_overflow <= 1'b0;
      else if (w_all9_roll) r_overflow <= 1'b1;

      if (clear)            r_limit_err <= 1'b0;
      else if (w_start_bad) r_limit_err <= 1'b1;
    end
  end

  assign count     = w_count;
  assign running   = r_running;
  assign done      = r_done;
  assign overflow  = r_overflow;
  assign limit_err = r_limit_err;

endmodule
